// File: rtl/tlc_phase_scheduler.sv
// Demand-driven round-robin phase scheduler for a four-way intersection.
// One approach is granted at a time; each grant runs GREEN -> YELLOW -> ALL_RED on tick-based timers.
module tlc_phase_scheduler #(
    parameter int CNT_W     = 8,
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 40,
    parameter int YELLOW    = 4,
    parameter int ALL_RED   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] req,
    output logic [3:0] red,
    output logic [3:0] yellow,
    output logic [3:0] green,
    output logic [1:0] phase,
    output logic [3:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_ALL_RED
    } state_e;

    localparam logic [CNT_W:0]   MIN_G     = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0]   MAX_G     = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W:0]   YEL_T     = (CNT_W+1)'(YELLOW);
    localparam logic [CNT_W:0]   RED_T     = (CNT_W+1)'(ALL_RED);
    localparam logic [CNT_W-1:0] TIMER_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       pending_q, pending_d;
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       red_q, red_d;
    logic [3:0]       yellow_q, yellow_d;
    logic [3:0]       green_q, green_d;

    logic [CNT_W:0]   elapsed;
    logic [3:0]       phase_oh;
    logic [3:0]       others;
    logic [1:0]       next_phase;
    logic [1:0]       cand;
    logic             grant_found;

    assign elapsed  = {1'b0, timer_q} + (CNT_W+1)'(1);
    assign phase_oh = 4'b0001 << phase_q;
    assign others   = pending_q & ~phase_oh;

    // Round-robin search starts just after the current phase, so the current approach comes last.
    always_comb begin
        grant_found = 1'b0;
        next_phase  = phase_q;
        cand        = phase_q;
        for (int k = 1; k <= 4; k++) begin
            cand = phase_q + 2'(k);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                next_phase  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    state_d = S_GREEN;
                    phase_d = next_phase;
                end
            end
            S_GREEN: begin
                if (tick && elapsed >= MIN_G && |others &&
                    (!req[phase_q] || elapsed >= MAX_G))
                    state_d = S_YELLOW;
            end
            S_YELLOW: begin
                if (tick && elapsed >= YEL_T)
                    state_d = S_ALL_RED;
            end
            S_ALL_RED: begin
                if (tick && elapsed >= RED_T) begin
                    if (|pending_q) begin
                        state_d = S_GREEN;
                        phase_d = next_phase;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timer restarts on any state change; otherwise it counts ticks and sticks at full scale.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)
            timer_d = '0;
        else if (tick && timer_q != TIMER_MAX)
            timer_d = timer_q + CNT_W'(1);
    end

    // The approach currently green neither latches nor keeps demand; a fresh grant drops its bit.
    always_comb begin
        pending_d = pending_q | req;
        if (state_q == S_GREEN)
            pending_d[phase_q] = 1'b0;
        if (state_d == S_GREEN && state_q != S_GREEN)
            pending_d[phase_d] = 1'b0;
    end

    // Lamps follow the next state so they switch on the same edge as the FSM.
    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        for (int i = 0; i < 4; i++) begin
            green_d[i]  = (state_d == S_GREEN)  && (phase_d == 2'(i));
            yellow_d[i] = (state_d == S_YELLOW) && (phase_d == 2'(i));
        end
        red_d = ~(green_d | yellow_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            pending_q <= '0;
            phase_q   <= 2'd3;
            red_q     <= 4'hF;
            yellow_q  <= '0;
            green_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            phase_q   <= phase_d;
            red_q     <= red_d;
            yellow_q  <= yellow_d;
            green_q   <= green_d;
        end
    end

    assign red     = red_q;
    assign yellow  = yellow_q;
    assign green   = green_q;
    assign phase   = phase_q;
    assign pending = pending_q;

endmodule
